// File: rtl/vga_scanout.sv
// VGA scanout for the CHIP-8 framebuffer: lores 64x32 or hires 128x64, scaled with sub-counters.
// Colour, syncs and blanking all travel the same two-tick fetch pipeline so they leave aligned.
module vga_scanout #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_NEG = 1'b1,
    parameter logic [11:0] FB_BASE  = 12'h000,
    parameter int unsigned LO_SX    = 10,
    parameter int unsigned LO_SY    = 15,
    parameter int unsigned HI_SX    = 5,
    parameter int unsigned HI_SY    = 7,
    parameter int unsigned HI_YOFF  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        timer_vga_tick,
    input  logic        hires,
    input  logic [11:0] fg_color,
    input  logic [11:0] bg_color,
    output logic [11:0] memory_addr,
    input  logic [7:0]  memory_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vblank,
    output logic        frame_pulse
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW = $clog2(H_TOTAL);
    localparam int unsigned VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_ON   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_OFF  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] LO_XEND = HW'(64 * LO_SX);
    localparam logic [HW-1:0] HI_XEND = HW'(128 * HI_SX);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_ON   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_OFF  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] LO_YEND = VW'(32 * LO_SY);
    localparam logic [VW-1:0] HI_YBEG = VW'(HI_YOFF);
    localparam logic [VW-1:0] HI_YEND = VW'(HI_YOFF + 64 * HI_SY);
    localparam logic [7:0]    LO_SX_LAST = 8'(LO_SX - 1);
    localparam logic [7:0]    LO_SY_LAST = 8'(LO_SY - 1);
    localparam logic [7:0]    HI_SX_LAST = 8'(HI_SX - 1);
    localparam logic [7:0]    HI_SY_LAST = 8'(HI_SY - 1);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          mode_q, mode_d;
    logic [7:0]    x_sub_q, x_sub_d, fb_x_q, fb_x_d;
    logic [7:0]    y_sub_q, y_sub_d, fb_y_q, fb_y_d;
    logic [11:0]   addr_q, addr_d;
    logic          s1_img_q, s1_img_d, s1_load_q, s1_load_d;
    logic [2:0]    s1_bit_q, s1_bit_d;
    logic          s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_vb_q, s1_vb_d;
    logic [7:0]    pix_byte_q, pix_byte_d;
    logic [11:0]   rgb_q, rgb_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    logic          vblank_q, vblank_d, frame_pulse_q, frame_pulse_d;

    logic          mode_eff, in_img, fetch;
    logic [7:0]    sx_last, sy_last;
    logic [11:0]   line_off, fetch_addr;

    always_comb begin
        h_d = h_q;  v_d = v_q;  mode_d = mode_q;
        x_sub_d = x_sub_q;  fb_x_d = fb_x_q;  y_sub_d = y_sub_q;  fb_y_d = fb_y_q;
        addr_d = addr_q;
        s1_img_d = s1_img_q;  s1_load_d = s1_load_q;  s1_bit_d = s1_bit_q;
        s1_hs_d = s1_hs_q;  s1_vs_d = s1_vs_q;  s1_vb_d = s1_vb_q;
        pix_byte_d = pix_byte_q;  rgb_d = rgb_q;
        hsync_d = hsync_q;  vsync_d = vsync_q;  vblank_d = vblank_q;
        frame_pulse_d = 1'b0;

        // The frame-start tick already scans with the mode it latches.
        mode_eff = (h_q == '0 && v_q == '0) ? hires : mode_q;
        sx_last  = mode_eff ? HI_SX_LAST : LO_SX_LAST;
        sy_last  = mode_eff ? HI_SY_LAST : LO_SY_LAST;
        if (mode_eff) begin
            in_img = (h_q < HI_XEND) && (v_q >= HI_YBEG) && (v_q < HI_YEND);
        end else begin
            in_img = (h_q < LO_XEND) && (v_q < LO_YEND);
        end
        fetch      = in_img && (fb_x_q[2:0] == 3'd0) && (x_sub_q == '0);
        line_off   = mode_eff ? {fb_y_q, 4'b0} : {1'b0, fb_y_q, 3'b0};
        fetch_addr = FB_BASE + line_off + {7'b0, fb_x_q[7:3]};

        if (timer_vga_tick) begin
            mode_d = mode_eff;
            if (h_q == H_LAST) begin
                h_d = '0;  x_sub_d = '0;  fb_x_d = '0;
                if (v_q == V_LAST) begin
                    v_d = '0;  y_sub_d = '0;  fb_y_d = '0;
                end else begin
                    v_d = v_q + 1'b1;
                    // Hires rows only start counting once the letterbox is passed.
                    if (!mode_eff || v_q >= HI_YBEG) begin
                        if (y_sub_q == sy_last) begin
                            y_sub_d = '0;
                            fb_y_d  = fb_y_q + 1'b1;
                        end else begin
                            y_sub_d = y_sub_q + 1'b1;
                        end
                    end
                end
            end else begin
                h_d = h_q + 1'b1;
                if (x_sub_q == sx_last) begin
                    x_sub_d = '0;
                    fb_x_d  = fb_x_q + 1'b1;
                end else begin
                    x_sub_d = x_sub_q + 1'b1;
                end
            end

            if (fetch) addr_d = fetch_addr;
            s1_img_d  = in_img;
            s1_load_d = fetch;
            s1_bit_d  = ~fb_x_q[2:0];
            s1_hs_d   = (h_q >= HS_ON) && (h_q < HS_OFF);
            s1_vs_d   = (v_q >= VS_ON) && (v_q < VS_OFF);
            s1_vb_d   = (v_q >= V_ACT);

            if (s1_load_q) pix_byte_d = memory_data;
            if (!s1_img_q) begin
                rgb_d = '0;
            end else if (pix_byte_d[s1_bit_q]) begin
                rgb_d = fg_color;
            end else begin
                rgb_d = bg_color;
            end
            hsync_d       = s1_hs_q ^ SYNC_NEG;
            vsync_d       = s1_vs_q ^ SYNC_NEG;
            vblank_d      = s1_vb_q;
            frame_pulse_d = s1_vb_q && !vblank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q <= '0;  v_q <= '0;  mode_q <= 1'b0;
            x_sub_q <= '0;  fb_x_q <= '0;  y_sub_q <= '0;  fb_y_q <= '0;
            addr_q <= FB_BASE;
            s1_img_q <= 1'b0;  s1_load_q <= 1'b0;  s1_bit_q <= '0;
            s1_hs_q <= 1'b0;  s1_vs_q <= 1'b0;  s1_vb_q <= 1'b0;
            pix_byte_q <= '0;  rgb_q <= '0;
            hsync_q <= SYNC_NEG;  vsync_q <= SYNC_NEG;
            vblank_q <= 1'b0;  frame_pulse_q <= 1'b0;
        end else begin
            h_q <= h_d;  v_q <= v_d;  mode_q <= mode_d;
            x_sub_q <= x_sub_d;  fb_x_q <= fb_x_d;  y_sub_q <= y_sub_d;  fb_y_q <= fb_y_d;
            addr_q <= addr_d;
            s1_img_q <= s1_img_d;  s1_load_q <= s1_load_d;  s1_bit_q <= s1_bit_d;
            s1_hs_q <= s1_hs_d;  s1_vs_q <= s1_vs_d;  s1_vb_q <= s1_vb_d;
            pix_byte_q <= pix_byte_d;  rgb_q <= rgb_d;
            hsync_q <= hsync_d;  vsync_q <= vsync_d;
            vblank_q <= vblank_d;  frame_pulse_q <= frame_pulse_d;
        end
    end

    assign memory_addr = addr_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vblank      = vblank_q;
    assign frame_pulse = frame_pulse_q;
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shrunken raster; a per-pixel arithmetic model predicts every pin
// two ticks after the raster position, using a random VRAM image behind a synchronous read port.
module tb_vga_scanout;
    localparam int H_ACTIVE = 132, H_FP = 3, H_SYNC = 6, H_BP = 3;
    localparam int V_ACTIVE = 68, V_FP = 2, V_SYNC = 2, V_BP = 2;
    localparam int LO_SX = 2, LO_SY = 2, HI_SX = 1, HI_SY = 1, HI_YOFF = 2;
    localparam logic SYNC_NEG = 1'b1;
    localparam logic [11:0] FB_BASE = 12'hFF0;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME_TICKS = H_TOTAL * V_TOTAL;

    logic        clk = 1'b0;
    logic        reset, timer_vga_tick, hires;
    logic [11:0] fg_color, bg_color, memory_addr;
    logic [7:0]  memory_data;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync, vblank, frame_pulse;

    always #5 clk = ~clk;

    vga_scanout #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_NEG(SYNC_NEG), .FB_BASE(FB_BASE),
        .LO_SX(LO_SX), .LO_SY(LO_SY), .HI_SX(HI_SX), .HI_SY(HI_SY), .HI_YOFF(HI_YOFF)
    ) dut (
        .clk(clk), .reset(reset), .timer_vga_tick(timer_vga_tick), .hires(hires),
        .fg_color(fg_color), .bg_color(bg_color),
        .memory_addr(memory_addr), .memory_data(memory_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vblank(vblank), .frame_pulse(frame_pulse)
    );

    logic [7:0] mem [4096];
    always @(posedge clk) memory_data <= mem[memory_addr];

    int          vec, errs, fp_seen, fp_mark, hs_run;
    int          mh, mv, p_h, p_v;
    logic        mmode, p_valid, p_mode;
    logic [11:0] e_rgb, e_addr;
    logic        e_hs, e_vs, e_vb, e_fp;

    function automatic logic img_at(input int h, input int v, input logic m);
        if (m) return (h < 128 * HI_SX) && (v >= HI_YOFF) && (v < HI_YOFF + 64 * HI_SY);
        return (h < 64 * LO_SX) && (v < 32 * LO_SY);
    endfunction

    function automatic int xpix(input int h, input logic m);
        return m ? h / HI_SX : h / LO_SX;
    endfunction

    function automatic logic [11:0] byte_addr(input int h, input int v, input logic m);
        int y, a;
        y = m ? (v - HI_YOFF) / HI_SY : v / LO_SY;
        a = int'(FB_BASE) + y * (m ? 16 : 8) + xpix(h, m) / 8;
        return 12'(a % 4096);
    endfunction

    task automatic model_edge(input logic tk, input logic rst);
        logic       m, nvb;
        logic [7:0] b;
        e_fp = 1'b0;
        if (rst) begin
            mh = 0;  mv = 0;  mmode = 1'b0;  p_valid = 1'b0;
            e_rgb = '0;  e_addr = FB_BASE;  e_hs = SYNC_NEG;  e_vs = SYNC_NEG;  e_vb = 1'b0;
        end else if (tk) begin
            m = (mh == 0 && mv == 0) ? hires : mmode;
            mmode = m;
            if (p_valid) begin
                if (img_at(p_h, p_v, p_mode)) begin
                    b = mem[byte_addr(p_h, p_v, p_mode)];
                    e_rgb = b[7 - xpix(p_h, p_mode) % 8] ? fg_color : bg_color;
                end else begin
                    e_rgb = '0;
                end
                e_hs = (p_h >= H_ACTIVE + H_FP && p_h < H_ACTIVE + H_FP + H_SYNC) ^ SYNC_NEG;
                e_vs = (p_v >= V_ACTIVE + V_FP && p_v < V_ACTIVE + V_FP + V_SYNC) ^ SYNC_NEG;
                nvb  = (p_v >= V_ACTIVE);
                e_fp = nvb && !e_vb;
                e_vb = nvb;
            end
            if (img_at(mh, mv, m) && (mh % (8 * (m ? HI_SX : LO_SX))) == 0)
                e_addr = byte_addr(mh, mv, m);
            p_valid = 1'b1;  p_h = mh;  p_v = mv;  p_mode = m;
            mh++;
            if (mh == H_TOTAL) begin
                mh = 0;
                mv++;
                if (mv == V_TOTAL) mv = 0;
            end
        end
    endtask

    task automatic check(input logic tk, input logic rst);
        vec++;
        assert ({vga_r, vga_g, vga_b} === e_rgb) else begin
            errs++;
            $error("FAIL rgb (model h=%0d v=%0d): got %h expected %h", mh, mv, {vga_r, vga_g, vga_b}, e_rgb);
        end
        vec++;
        assert (memory_addr === e_addr) else begin
            errs++;
            $error("FAIL addr (model h=%0d v=%0d): got %h expected %h", mh, mv, memory_addr, e_addr);
        end
        vec++;
        assert ({vga_hsync, vga_vsync, vblank, frame_pulse} === {e_hs, e_vs, e_vb, e_fp}) else begin
            errs++;
            $error("FAIL ctrl hs/vs/vb/fp (model h=%0d v=%0d): got %b expected %b", mh, mv,
                   {vga_hsync, vga_vsync, vblank, frame_pulse}, {e_hs, e_vs, e_vb, e_fp});
        end
        if (frame_pulse === 1'b1) fp_seen++;
        if (rst) begin
            hs_run = 0;
        end else if (tk) begin
            if (vga_hsync === 1'b0) begin
                hs_run++;
            end else if (hs_run != 0) begin
                vec++;
                assert (hs_run == H_SYNC) else begin
                    errs++;
                    $error("FAIL hsync_width: got %0d ticks expected %0d", hs_run, H_SYNC);
                end
                hs_run = 0;
            end
        end
    endtask

    task automatic step(input logic tk, input logic rst);
        @(negedge clk);
        timer_vga_tick = tk;
        reset = rst;
        if ($urandom_range(0, 299) == 0) begin
            fg_color = 12'($urandom);
            bg_color = 12'($urandom);
        end
        @(posedge clk);
        model_edge(tk, rst);
        #1;
        check(tk, rst);
    endtask

    // One pixel tick followed by 1-2 idle clocks, as the VRAM needs a clock to answer.
    task automatic tick_step();
        step(1'b1, 1'b0);
        repeat (1 + int'($urandom_range(0, 3) == 0)) step(1'b0, 1'b0);
    endtask

    task automatic run_to(input int th, input int tv);
        int n;
        n = 0;
        do begin
            tick_step();
            n++;
        end while (!(mh == th && mv == tv) && n < FRAME_TICKS + 10);
        if (!(mh == th && mv == tv)) begin
            vec++;
            errs++;
            $error("FAIL run_to timeout: at h=%0d v=%0d expected h=%0d v=%0d", mh, mv, th, tv);
        end
    endtask

    task automatic check_reset_pins(input string tag);
        vec++;
        assert (memory_addr === FB_BASE) else begin
            errs++;
            $error("FAIL %s addr: got %h expected %h", tag, memory_addr, FB_BASE);
        end
        vec++;
        assert ({vga_hsync, vga_vsync} === {SYNC_NEG, SYNC_NEG}) else begin
            errs++;
            $error("FAIL %s syncs: got %b expected %b", tag, {vga_hsync, vga_vsync}, {SYNC_NEG, SYNC_NEG});
        end
        vec++;
        assert ({vga_r, vga_g, vga_b, vblank, frame_pulse} === 14'b0) else begin
            errs++;
            $error("FAIL %s rgb/vb/fp: got %h expected 0", tag, {vga_r, vga_g, vga_b, vblank, frame_pulse});
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        vec = 0;  errs = 0;  fp_seen = 0;  hs_run = 0;
        reset = 1'b1;  timer_vga_tick = 1'b1;  hires = 1'b0;
        fg_color = 12'hFFF;  bg_color = 12'h00F;

        repeat (4) step(1'b1, 1'b1);
        check_reset_pins("reset");
        step(1'b0, 1'b0);

        // Lores frame; a hires request mid-frame must wait for the next frame.
        fp_mark = fp_seen;
        run_to(0, 20);
        hires = 1'b1;
        run_to(0, 0);
        vec++;
        assert (fp_seen - fp_mark == 1) else begin
            errs++;
            $error("FAIL frame_pulse_count lores: got %0d expected 1", fp_seen - fp_mark);
        end

        // Hires frame with a 50-clock tick stall mid-line.
        fp_mark = fp_seen;
        run_to(50, 30);
        repeat (50) step(1'b0, 1'b0);
        hires = 1'b0;
        run_to(0, 0);
        vec++;
        assert (fp_seen - fp_mark == 1) else begin
            errs++;
            $error("FAIL frame_pulse_count hires: got %0d expected 1", fp_seen - fp_mark);
        end

        // Reset pulse mid-line, then resume with a random mode.
        run_to(60, 10);
        step(1'b1, 1'b1);
        check_reset_pins("midline_reset");
        step(1'b0, 1'b0);
        hires = 1'($urandom_range(0, 1));
        run_to(0, 12);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
